instr_mem_responder: RTL

//   Instruction-side memory responder: the far end of the fetch-address path driven by the PC incrementer.

---
 rtl/instr_mem_responder_if.sv | 37 +++
 rtl/instr_mem_responder.sv | 128 ++++++++++++
 2 files changed

// File: rtl/instr_mem_responder_if.sv
// Fetch request/response bundle between the PC stage and the instruction memory responder.
// o_i_misalign exists only when IMEM_ALIGN_CHK_EN is defined.
interface instr_mem_responder_if #(
   parameter int DATA_W = 64,
   parameter int INST_W = 32
);
   logic [DATA_W-1:0] i_i_addr;
   logic              i_i_valid_addr;
   logic              o_i_ready;
   logic [INST_W-1:0] o_i_inst;
   logic              o_i_valid_inst;
`ifdef IMEM_ALIGN_CHK_EN
   logic              o_i_misalign;
`endif

   modport master (
      output i_i_addr,
      output i_i_valid_addr,
      input  o_i_ready,
      input  o_i_inst,
      input  o_i_valid_inst
`ifdef IMEM_ALIGN_CHK_EN
      , input o_i_misalign
`endif
   );

   modport slave (
      input  i_i_addr,
      input  i_i_valid_addr,
      output o_i_ready,
      output o_i_inst,
      output o_i_valid_inst
`ifdef IMEM_ALIGN_CHK_EN
      , output o_i_misalign
`endif
   );
endinterface

// File: rtl/instr_mem_responder.sv
// Instruction memory responder: single outstanding fetch, fixed LATENCY, preloadable storage.
// Optional IMEM_ALIGN_CHK_EN: misaligned fetches return a NOP and flag o_i_misalign.
module instr_mem_responder #(
   parameter int DATA_W  = 64,
   parameter int INST_W  = 32,
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   instr_mem_responder_if.slave     bus,
   input  logic                     i_ld_en,
   input  logic [$clog2(DEPTH)-1:0] i_ld_addr,
   input  logic [INST_W-1:0]        i_ld_data
);
   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = $clog2(LATENCY + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [1:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [AW+1:0]     addr_q, addr_d;
   logic [INST_W-1:0] rdata_q, rdata_d;
   logic [INST_W-1:0] inst_q, inst_d;
   logic              valid_q, valid_d;
   logic [INST_W-1:0] mem_q [DEPTH];

`ifdef IMEM_ALIGN_CHK_EN
   localparam logic [INST_W-1:0] NOP = INST_W'(32'h0000_0013);
   logic misalign_q, misalign_d;
   logic unused_addr;
   assign unused_addr = ^bus.i_i_addr[DATA_W-1:AW+2];
`else
   logic unused_addr;
   assign unused_addr = ^{bus.i_i_addr[DATA_W-1:AW+2], addr_q[1:0]};
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      rdata_d = rdata_q;
      inst_d  = inst_q;
      valid_d = 1'b0;
`ifdef IMEM_ALIGN_CHK_EN
      misalign_d = misalign_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (bus.i_i_valid_addr) begin
               addr_d = bus.i_i_addr[AW+1:0];
               // Storage is sampled on the edge entering RESP, so same-edge preloads are not seen.
               if (LATENCY == 1) begin
                  state_d = S_RESP;
                  rdata_d = mem_q[bus.i_i_addr[2 +: AW]];
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = CNT_INIT;
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == CNT_ONE) begin
               state_d = S_RESP;
               cnt_d   = '0;
               rdata_d = mem_q[addr_q[2 +: AW]];
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
            valid_d = 1'b1;
`ifdef IMEM_ALIGN_CHK_EN
            misalign_d = (addr_q[1:0] != 2'b00);
            inst_d     = misalign_d ? NOP : rdata_q;
`else
            inst_d     = rdata_q;
`endif
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         rdata_q <= '0;
         inst_q  <= '0;
         valid_q <= 1'b0;
`ifdef IMEM_ALIGN_CHK_EN
         misalign_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         rdata_q <= rdata_d;
         inst_q  <= inst_d;
         valid_q <= valid_d;
`ifdef IMEM_ALIGN_CHK_EN
         misalign_q <= misalign_d;
`endif
      end
   end

   // Storage is deliberately outside the reset domain.
   always_ff @(posedge i_clk) begin
      if (i_ld_en) begin
         mem_q[i_ld_addr] <= i_ld_data;
      end
   end

   assign bus.o_i_ready      = (state_q == S_IDLE);
   assign bus.o_i_inst       = inst_q;
   assign bus.o_i_valid_inst = valid_q;
`ifdef IMEM_ALIGN_CHK_EN
   assign bus.o_i_misalign   = misalign_q;
`endif
endmodule
